// File: rtl/ps2_tx_multi.sv
// ps2_tx_multi -- multi-channel PS/2 device-side byte transmitter.
//
// Each channel owns a byte FIFO and a frame FSM that shifts out 11-bit
// PS/2 frames (start 0, 8 data bits LSB first, odd parity, stop 1).
// All channels step on one shared tick derived from clk_sys.
//
// Optional feature: define PS2_TX_INHIBIT_EN to honour host inhibit
// (host pulling the clock line low aborts and later retries a frame).
//
// Ports:
//   clk_sys       system clock, rising edge
//   reset         synchronous active-high reset
//   wr_strobe     one-cycle byte write request
//   wr_chan       target channel (out-of-range values are ignored)
//   wr_data       byte to queue
//   ps2_clk_in    sensed clock line per channel (0 = held low by host)
//   ps2_clk_out   driven clock per channel (1 = released)
//   ps2_data_out  driven data per channel (1 = released)
//   fifo_full     FIFO holds 2^FIFO_BITS bytes
//   overflow      sticky: a write to a full FIFO was dropped
//   busy          frame in progress or waiting out an inhibit
module ps2_tx_multi #(
  parameter int CHANNELS  = 2,
  parameter int FIFO_BITS = 3,
  parameter int CLK_DIV   = 1000,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                wr_strobe,
  input  logic [CW-1:0]       wr_chan,
  input  logic [7:0]          wr_data,
  input  logic [CHANNELS-1:0] ps2_clk_in,
  output logic [CHANNELS-1:0] ps2_clk_out,
  output logic [CHANNELS-1:0] ps2_data_out,
  output logic [CHANNELS-1:0] fifo_full,
  output logic [CHANNELS-1:0] overflow,
  output logic [CHANNELS-1:0] busy
);

  localparam int DW    = $clog2(CLK_DIV);
  localparam int DEPTH = 2 ** FIFO_BITS;

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_INHIBIT} state_t;

  logic [DW-1:0] cnt;
  logic          tick;

  state_t        state_q [CHANNELS];
  state_t        state_d [CHANNELS];
  logic [10:0]   frame_q [CHANNELS];
  logic [10:0]   frame_d [CHANNELS];
  logic [3:0]    idx_q   [CHANNELS];
  logic [3:0]    idx_d   [CHANNELS];
  logic [3:0]    idx_n;

  logic [CHANNELS-1:0] clk_q, clk_d, dat_q, dat_d;
  logic [CHANNELS-1:0] pop, push, empty, full_w, inhib, ovf_q;

  logic [FIFO_BITS:0] wr_ptr [CHANNELS];
  logic [FIFO_BITS:0] rd_ptr [CHANNELS];
  logic [7:0]         mem    [CHANNELS][DEPTH];
  logic [7:0]         head   [CHANNELS];

  assign tick = (cnt == DW'(CLK_DIV - 1));

  // FIFO status; pointers carry one extra wrap bit to tell full from empty.
  always_comb begin
    empty  = '0;
    full_w = '0;
    push   = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      head[c]   = mem[c][rd_ptr[c][FIFO_BITS-1:0]];
      empty[c]  = (wr_ptr[c] == rd_ptr[c]);
      full_w[c] = (wr_ptr[c][FIFO_BITS] != rd_ptr[c][FIFO_BITS]) &&
                  (wr_ptr[c][FIFO_BITS-1:0] == rd_ptr[c][FIFO_BITS-1:0]);
      // Fullness is judged before any same-cycle pop, so a write to a
      // full FIFO is always dropped.
      push[c]   = wr_strobe && (wr_chan == CW'(c)) && !full_w[c];
    end
  end

`ifdef PS2_TX_INHIBIT_EN
  assign inhib = ~ps2_clk_in & clk_q;
`else
  logic unused_clk_in;
  assign unused_clk_in = ^ps2_clk_in;
  assign inhib = '0;
`endif

  always_comb begin
    clk_d = clk_q;
    dat_d = dat_q;
    pop   = '0;
    idx_n = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      frame_d[c] = frame_q[c];
      idx_d[c]   = idx_q[c];
      idx_n      = idx_q[c] + 4'd1;
      case (state_q[c])
        S_IDLE: begin
          if (tick && !empty[c] && !inhib[c]) begin
            pop[c]     = 1'b1;
            frame_d[c] = {1'b1, ~^head[c], head[c], 1'b0};
            idx_d[c]   = '0;
            dat_d[c]   = 1'b0;
            state_d[c] = S_HIGH;
          end
        end
        S_HIGH: begin
          if (tick) begin
            if (inhib[c] && idx_q[c] != 4'd10) begin
              clk_d[c]   = 1'b1;
              dat_d[c]   = 1'b1;
              state_d[c] = S_INHIBIT;
            end else begin
              clk_d[c]   = 1'b0;
              state_d[c] = S_LOW;
            end
          end
        end
        S_LOW: begin
          if (tick) begin
            clk_d[c] = 1'b1;
            if (idx_q[c] == 4'd10) begin
              dat_d[c]   = 1'b1;
              state_d[c] = S_IDLE;
            end else begin
              idx_d[c]   = idx_n;
              dat_d[c]   = frame_q[c][idx_n];
              state_d[c] = S_HIGH;
            end
          end
        end
        S_INHIBIT: begin
`ifdef PS2_TX_INHIBIT_EN
          // The byte stays in frame_q, so the retry needs no FIFO access.
          if (tick && ps2_clk_in[c]) begin
            idx_d[c]   = '0;
            dat_d[c]   = frame_q[c][0];
            state_d[c] = S_HIGH;
          end
`else
          state_d[c] = S_IDLE;
`endif
        end
        default: state_d[c] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt   <= '0;
      clk_q <= '1;
      dat_q <= '1;
      ovf_q <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        state_q[c] <= S_IDLE;
        frame_q[c] <= '0;
        idx_q[c]   <= '0;
        wr_ptr[c]  <= '0;
        rd_ptr[c]  <= '0;
      end
    end else begin
      cnt   <= tick ? '0 : cnt + DW'(1);
      clk_q <= clk_d;
      dat_q <= dat_d;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        frame_q[c] <= frame_d[c];
        idx_q[c]   <= idx_d[c];
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
        if (wr_strobe && (wr_chan == CW'(c)) && full_w[c]) ovf_q[c] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (push[c]) mem[c][wr_ptr[c][FIFO_BITS-1:0]] <= wr_data;
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      busy[c] = (state_q[c] != S_IDLE);
    end
  end

  assign ps2_clk_out  = clk_q;
  assign ps2_data_out = dat_q;
  assign fifo_full    = full_w;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_ps2_tx_multi.sv
// tb_ps2_tx_multi -- directed self-checking bench for ps2_tx_multi.
// Three channels so that an out-of-range wr_chan value is representable.
module tb_ps2_tx_multi;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       wr_strobe;
  logic [1:0] wr_chan;
  logic [7:0] wr_data;
  logic [2:0] ps2_clk_in;
  logic [2:0] ps2_clk_out, ps2_data_out, fifo_full, overflow, busy;

  int checks   = 0;
  int failures = 0;

  ps2_tx_multi #(.CHANNELS(3), .FIFO_BITS(3), .CLK_DIV(4)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .wr_strobe    (wr_strobe),
    .wr_chan      (wr_chan),
    .wr_data      (wr_data),
    .ps2_clk_in   (ps2_clk_in),
    .ps2_clk_out  (ps2_clk_out),
    .ps2_data_out (ps2_data_out),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] d);
    @(negedge clk_sys);
    wr_strobe = 1'b1;
    wr_chan   = ch;
    wr_data   = d;
    @(negedge clk_sys);
    wr_strobe = 1'b0;
  endtask

  task automatic wait_busy(input int unsigned ch, input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (busy[ch] === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, found, 1);
  endtask

  // exp[i] is the expected line level for frame bit i (0 = start, 10 = stop).
  // Each bit lasts 8 cycles: 4 with clock released, then 4 with clock low.
  task automatic check_frame(input int unsigned ch, input logic [10:0] exp, input string tag);
    logic found = 1'b0;
    int   bcnt  = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_sys);
      if (ps2_data_out[ch] === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_start_timeout"}, found, 1);
    if (found) begin
      for (int k = 0; k < 100; k++) begin
        if (k > 0) @(negedge clk_sys);
        if (k < 88 && k % 8 == 2) chk($sformatf("%s_bit%0d", tag, k / 8), ps2_data_out[ch], exp[k / 8]);
        if (k < 88 && k % 8 == 6) chk($sformatf("%s_clklow%0d", tag, k / 8), ps2_clk_out[ch], 0);
        if (busy[ch] === 1'b1) bcnt++;
      end
      chk({tag, "_busy_cycles"}, bcnt, 88);
      chk({tag, "_data_released"}, ps2_data_out[ch], 1);
      chk({tag, "_clk_released"}, ps2_clk_out[ch], 1);
    end
  endtask

  initial begin
    int busy_seen;
    reset      = 1'b1;
    wr_strobe  = 1'b0;
    wr_chan    = '0;
    wr_data    = '0;
    ps2_clk_in = 3'b111;
    repeat (3) @(negedge clk_sys);
    chk("rst_clk_out", ps2_clk_out, 3'b111);
    chk("rst_data_out", ps2_data_out, 3'b111);
    chk("rst_busy", busy, 3'b000);
    chk("rst_full", fifo_full, 3'b000);
    chk("rst_ovf", overflow, 3'b000);
    reset = 1'b0;

    // 0x1C on ch0: 0,0,0,1,1,1,0,0,0, parity 0, stop 1
    wr(2'd0, 8'h1C);
    check_frame(0, 11'b10000111000, "f1C");
    chk("f1C_others_idle", busy, 3'b000);

`ifndef PS2_TX_INHIBIT_EN
    // Clock input held low must not matter without inhibit support.
    ps2_clk_in = 3'b000;
    wr(2'd2, 8'h55);
    check_frame(2, 11'b11010101010, "f55");
    ps2_clk_in = 3'b111;
`else
    // Inhibit ch0 during bit 4 of 0xA5, then release and expect a full retry.
    begin
      logic found = 1'b0;
      wr(2'd0, 8'hA5);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk_sys);
        if (ps2_data_out[0] === 1'b0) begin
          found = 1'b1;
          break;
        end
      end
      chk("inh_start_timeout", found, 1);
      repeat (33) @(negedge clk_sys);
      ps2_clk_in[0] = 1'b0;
      repeat (4) @(negedge clk_sys);
      chk("inh_clk_released", ps2_clk_out[0], 1);
      chk("inh_data_released", ps2_data_out[0], 1);
      chk("inh_busy", busy[0], 1);
      repeat (4) @(negedge clk_sys);
      ps2_clk_in[0] = 1'b1;
      check_frame(0, 11'b11101001010, "fA5_retry");
      chk("inh_no_second_frame", busy, 3'b000);
    end
`endif

    // Fill ch1 while it is busy sending a first byte: 8 stored, 9th dropped.
    wr(2'd1, 8'h11);
    wait_busy(1, "ovf_busy_timeout");
    for (int i = 0; i < 7; i++) wr(2'd1, 8'(8'h20 + i));
    chk("ovf_not_full_at7", fifo_full[1], 0);
    wr(2'd1, 8'h27);
    chk("ovf_full_at8", fifo_full, 3'b010);
    chk("ovf_clear_at8", overflow, 3'b000);
    wr(2'd1, 8'h28);
    chk("ovf_set_at9", overflow, 3'b010);
    chk("ovf_still_full", fifo_full, 3'b010);

    // Out-of-range channel: no storage, no overflow anywhere.
    wr(2'd3, 8'hFF);
    chk("badch_ovf", overflow, 3'b010);
    chk("badch_full", fifo_full, 3'b010);
    repeat (12) @(negedge clk_sys);
    chk("badch_idle", busy, 3'b010);

    // Reset mid-frame with bytes queued on ch1.
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    chk("mid_rst_clk_out", ps2_clk_out, 3'b111);
    chk("mid_rst_data_out", ps2_data_out, 3'b111);
    chk("mid_rst_busy", busy, 3'b000);
    chk("mid_rst_full", fifo_full, 3'b000);
    chk("mid_rst_ovf", overflow, 3'b000);
    busy_seen = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk_sys);
      if (busy !== 3'b000 || ps2_data_out !== 3'b111) busy_seen++;
    end
    chk("mid_rst_no_frame", busy_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
